// File: rtl/vga_trace_prefetch_if.sv
// Port bundle for the VGA trace prefetch scheduler: timing pulses, CPU/RAM port, pixel read side.
// The stats counters exist only when PREFETCH_STATS_EN is defined.
interface vga_trace_prefetch_if #(
    parameter int ADDR_W = 12
);
    logic              frame_start;
    logic              line_start;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [8:0]        rd_idx;
    logic [7:0]        rd_sample;
    logic [31:0]       value;
    logic              value_valid;
    logic              overrun;
    logic [1:0]        dbg_state;
`ifdef PREFETCH_STATS_EN
    logic [15:0]       stall_cnt;
    logic [7:0]        ovr_cnt;
`endif

    // There is no valid/ready pair here: cpu_req is granted the same cycle it is
    // raised, and mem_data always answers the address presented one cycle earlier.
    modport master (
        output frame_start, line_start, cpu_req, cpu_addr, mem_data, rd_idx,
        input  cpu_gnt, mem_addr, rd_sample, value, value_valid, overrun, dbg_state
`ifdef PREFETCH_STATS_EN
        , input stall_cnt, ovr_cnt
`endif
    );

    modport slave (
        input  frame_start, line_start, cpu_req, cpu_addr, mem_data, rd_idx,
        output cpu_gnt, mem_addr, rd_sample, value, value_valid, overrun, dbg_state
`ifdef PREFETCH_STATS_EN
        , output stall_cnt, ovr_cnt
`endif
    );
endinterface

// File: rtl/vga_trace_prefetch.sv
// Scanline prefetch scheduler: CPU-priority arbitration of the signal-RAM port, ping-pong
// line buffer fill and per-frame readout fetch. Optional counters under PREFETCH_STATS_EN.
module vga_trace_prefetch #(
    parameter int                SAMPLES    = 320,
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 12'h559,
    parameter logic [ADDR_W-1:0] VALUE_ADDR = 12'h6A8,
    parameter int                SAMPLE_LSB = 4
) (
    input logic                 i_clock,
    input logic                 i_reset,
    vga_trace_prefetch_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VALUE = 2'd1,
        S_LINE  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [9:0] SAMPLES_W = 10'(SAMPLES);
    localparam logic [8:0] LAST_IDX  = 9'(SAMPLES - 1);

    state_t      r_state;
    logic [9:0]  r_idx;
    logic [8:0]  r_ret_idx;
    logic        r_in_flight;
    logic        r_fl_value;
    logic        r_val_issued;
    logic        r_line_pend;
    logic        r_frame_pend;
    logic        r_back_full;
    logic        r_front_sel;
    logic        r_swapped;
    logic        r_value_valid;
    logic        r_overrun;
    logic [31:0] r_value;
    logic [7:0]  r_rd_sample;
    logic [7:0]  r_buf0 [SAMPLES];
    logic [7:0]  r_buf1 [SAMPLES];

    logic              w_want;
    logic              w_issue;
    logic              w_ret_sample;
    logic              w_ret_value;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic [7:0]        w_sample;

    // A line_start seen in LINE restarts the burst, so no issue is made on that cycle.
    assign w_want = ((r_state == S_LINE) && (r_idx < SAMPLES_W) && !bus.line_start) ||
                    ((r_state == S_VALUE) && !r_val_issued);
    assign w_issue      = w_want && !bus.cpu_req;
    assign w_ret_sample = r_in_flight && !r_fl_value;
    assign w_ret_value  = r_in_flight && r_fl_value;
    assign w_sample     = bus.mem_data[SAMPLE_LSB +: 8];

    always_comb begin
        w_fetch_addr = '0;
        if (r_state == S_LINE)
            w_fetch_addr = BASE_ADDR + ADDR_W'(r_idx);
        else if (r_state == S_VALUE)
            w_fetch_addr = VALUE_ADDR;
    end

    assign bus.mem_addr    = bus.cpu_req ? bus.cpu_addr : w_fetch_addr;
    assign bus.cpu_gnt     = bus.cpu_req;
    assign bus.rd_sample   = r_rd_sample;
    assign bus.value       = r_value;
    assign bus.value_valid = r_value_valid;
    assign bus.overrun     = r_overrun;
    assign bus.dbg_state   = r_state;

    // Buffer RAM carries no reset; a return landing on a reset cycle is dropped.
    always_ff @(posedge i_clock) begin
        if (i_reset && w_ret_sample) begin
            if (r_front_sel)
                r_buf0[r_ret_idx] <= w_sample;
            else
                r_buf1[r_ret_idx] <= w_sample;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_ret_idx     <= '0;
            r_in_flight   <= 1'b0;
            r_fl_value    <= 1'b0;
            r_val_issued  <= 1'b0;
            r_line_pend   <= 1'b0;
            r_frame_pend  <= 1'b0;
            r_back_full   <= 1'b0;
            r_front_sel   <= 1'b0;
            r_swapped     <= 1'b0;
            r_value_valid <= 1'b0;
            r_overrun     <= 1'b0;
            r_value       <= '0;
            r_rd_sample   <= '0;
        end else begin
            r_in_flight <= w_issue;
            r_fl_value  <= (r_state == S_VALUE);
            if (w_issue && (r_state == S_LINE))
                r_ret_idx <= r_idx[8:0];

            if (r_swapped && ({1'b0, bus.rd_idx} < SAMPLES_W))
                r_rd_sample <= r_front_sel ? r_buf1[bus.rd_idx] : r_buf0[bus.rd_idx];
            else
                r_rd_sample <= '0;

            case (r_state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        r_state     <= S_VALUE;
                        r_line_pend <= bus.line_start;
                    end else if (bus.line_start) begin
                        r_state     <= S_LINE;
                        r_idx       <= '0;
                        r_line_pend <= 1'b0;
                        if (r_back_full) begin
                            r_front_sel <= ~r_front_sel;
                            r_swapped   <= 1'b1;
                            r_back_full <= 1'b0;
                        end
                    end
                end
                S_VALUE: begin
                    if (bus.line_start)
                        r_line_pend <= 1'b1;
                    if (w_issue)
                        r_val_issued <= 1'b1;
                    if (w_ret_value) begin
                        r_value       <= bus.mem_data;
                        r_value_valid <= 1'b1;
                        r_val_issued  <= 1'b0;
                        if (r_line_pend || bus.line_start) begin
                            r_state     <= S_LINE;
                            r_idx       <= '0;
                            r_line_pend <= 1'b0;
                            if (r_back_full) begin
                                r_front_sel <= ~r_front_sel;
                                r_swapped   <= 1'b1;
                                r_back_full <= 1'b0;
                            end
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_LINE: begin
                    if (bus.frame_start)
                        r_frame_pend <= 1'b1;
                    if (bus.line_start) begin
                        // Incomplete line: keep the old front and refill the same back half.
                        r_overrun <= 1'b1;
                        r_idx     <= '0;
                    end else begin
                        if (w_issue)
                            r_idx <= r_idx + 10'd1;
                        if (w_ret_sample && (r_ret_idx == LAST_IDX)) begin
                            r_state     <= S_DONE;
                            r_back_full <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.frame_start || r_frame_pend) begin
                        r_state      <= S_VALUE;
                        r_frame_pend <= 1'b0;
                        r_line_pend  <= bus.line_start;
                    end else if (bus.line_start) begin
                        r_state     <= S_LINE;
                        r_idx       <= '0;
                        r_line_pend <= 1'b0;
                        r_front_sel <= ~r_front_sel;
                        r_swapped   <= 1'b1;
                        r_back_full <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [7:0]  r_ovr_cnt;

    always_ff @(posedge i_clock) begin
        if (!i_reset || bus.frame_start) begin
            r_stall_cnt <= '0;
            r_ovr_cnt   <= '0;
        end else begin
            if (w_want && bus.cpu_req)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if ((r_state == S_LINE) && bus.line_start && (r_ovr_cnt != 8'hFF))
                r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.ovr_cnt   = r_ovr_cnt;
`endif
endmodule

// File: tb/tb_vga_trace_prefetch.sv
// Self-checking bench for vga_trace_prefetch: RAM model, scoreboard of expected samples,
// one task per scenario.
module tb_vga_trace_prefetch;
    localparam int SAMPLES = 320;
    localparam int ADDR_W  = 12;
    localparam int BASE    = 'h559;
    localparam int VADDR   = 'h6A8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_VALUE = 2'd1;
    localparam logic [1:0] ST_LINE  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          passed = 0;
    logic [31:0] ram [0:4095];
    logic [7:0]  exp_q [$];
    int          rd_list [9] = '{17, 0, 1, 100, 255, 256, 319, 320, 511};

    vga_trace_prefetch_if #(.ADDR_W(ADDR_W)) bus ();

    vga_trace_prefetch #(
        .SAMPLES(SAMPLES), .ADDR_W(ADDR_W), .BASE_ADDR(12'h559),
        .VALUE_ADDR(12'h6A8), .SAMPLE_LSB(4)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_data <= ram[bus.mem_addr];

    function automatic logic [7:0] exp_sample(input int pat, input int idx);
        if (pat == 0 || idx >= SAMPLES) return 8'h00;
        if (pat == 1) return 8'(idx);
        return 8'(idx) ^ 8'hA5;
    endfunction

    task automatic load_pattern(input int pat);
        logic [31:0] w;
        for (int i = 0; i < SAMPLES; i++) begin
            if (pat == 1) begin
                w = 32'(i) << 4;
            end else begin
                w = $urandom();
                w[11:4] = exp_sample(pat, i);
            end
            ram[(BASE + i) % 4096] = w;
        end
    endtask

    task automatic pulse(input logic fs, input logic ls);
        @(negedge clk);
        bus.frame_start = fs;
        bus.line_start  = ls;
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.line_start  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.frame_start = 0; bus.line_start = 0; bus.cpu_req = 0;
        bus.cpu_addr = '0; bus.rd_idx = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, ST_IDLE); else passed++;
        checks++; if (bus.mem_addr !== 12'h000) $display("FAIL reset_mem_addr: got %0h want 0", bus.mem_addr); else passed++;
        checks++; if (bus.value !== 32'd0 || bus.value_valid !== 1'b0) $display("FAIL reset_value: got %0h/%0b want 0/0", bus.value, bus.value_valid); else passed++;
        checks++; if (bus.overrun !== 1'b0 || bus.cpu_gnt !== 1'b0) $display("FAIL reset_flags: got ovr=%0b gnt=%0b want 0/0", bus.overrun, bus.cpu_gnt); else passed++;
        checks++; if (bus.rd_sample !== 8'd0) $display("FAIL reset_rd_sample: got %0h want 0", bus.rd_sample); else passed++;
`ifdef PREFETCH_STATS_EN
        checks++; if (bus.stall_cnt !== 16'd0 || bus.ovr_cnt !== 8'd0) $display("FAIL reset_stats: got %0d/%0d want 0/0", bus.stall_cnt, bus.ovr_cnt); else passed++;
`endif
    endtask

    task automatic test_value();
        int n;
        pulse(1'b1, 1'b0);
        n = 0;
        while (bus.value_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++; if (n > 3) $display("FAIL value_latency: got %0d cycles want <=3", n); else passed++;
        checks++; if (bus.value !== 32'd999) $display("FAIL value_word: got %0d want 999", bus.value); else passed++;
        @(negedge clk);
        checks++; if (bus.dbg_state !== ST_IDLE) $display("FAIL value_return_idle: got %0d want %0d", bus.dbg_state, ST_IDLE); else passed++;
    endtask

    task automatic test_line();
        int n;
        logic [7:0] e;
        pulse(1'b0, 1'b1);
        n = 0;
        while (bus.dbg_state !== ST_DONE && n < 2000) begin @(negedge clk); n++; end
        checks++; if (n != 321) $display("FAIL line_cycles: got %0d want 321", n); else passed++;
        load_pattern(2);
        pulse(1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            bus.rd_idx = 9'(rd_list[k]);
            exp_q.push_back(exp_sample(1, rd_list[k]));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (bus.rd_sample !== e) $display("FAIL line_sample[%0d]: got %0d want %0d", rd_list[k], bus.rd_sample, e); else passed++;
        end
    endtask

    task automatic test_cpu_interleave();
        int n;
        n = 0;
        while (bus.dbg_state !== ST_DONE && n < 2000) begin @(negedge clk); n++; end
        checks++; if (bus.dbg_state !== ST_DONE) $display("FAIL cpu_pre_done: got %0d want %0d", bus.dbg_state, ST_DONE); else passed++;
        load_pattern(1);
        pulse(1'b0, 1'b1);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 12'($urandom_range(0, 4095));
        n = 0;
        while (bus.dbg_state !== ST_DONE && n < 2000) begin
            @(negedge clk);
            n++;
            if (n <= 8) begin
                checks++; if (bus.cpu_gnt !== bus.cpu_req) $display("FAIL cpu_gnt: got %0b want %0b", bus.cpu_gnt, bus.cpu_req); else passed++;
                if (bus.cpu_req) begin
                    checks++; if (bus.mem_addr !== bus.cpu_addr) $display("FAIL cpu_mem_addr: got %0h want %0h", bus.mem_addr, bus.cpu_addr); else passed++;
                end
            end
            bus.cpu_req  = ~bus.cpu_req;
            bus.cpu_addr = 12'($urandom_range(0, 4095));
        end
        bus.cpu_req = 1'b0;
        checks++; if (n != 641) $display("FAIL cpu_line_cycles: got %0d want 641", n); else passed++;
`ifdef PREFETCH_STATS_EN
        checks++; if (bus.stall_cnt !== 16'd320) $display("FAIL stall_cnt: got %0d want 320", bus.stall_cnt); else passed++;
`endif
    endtask

    task automatic test_overrun();
        int n;
        logic [7:0] e;
        load_pattern(2);
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 12'h123;
        pulse(1'b0, 1'b1);
        repeat (200) @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.mem_addr !== 12'h123) $display("FAIL ovr_cpu_hold: got gnt=%0b addr=%0h want 1/123", bus.cpu_gnt, bus.mem_addr); else passed++;
        pulse(1'b0, 1'b1);
        repeat (196) @(negedge clk);
        bus.cpu_req = 1'b0;
        checks++; if (bus.overrun !== 1'b1) $display("FAIL overrun_flag: got %0b want 1", bus.overrun); else passed++;
        checks++; if (bus.dbg_state !== ST_LINE) $display("FAIL overrun_state: got %0d want %0d", bus.dbg_state, ST_LINE); else passed++;
`ifdef PREFETCH_STATS_EN
        checks++; if (bus.ovr_cnt !== 8'd1) $display("FAIL ovr_cnt: got %0d want 1", bus.ovr_cnt); else passed++;
`endif
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            bus.rd_idx = 9'(rd_list[k]);
            exp_q.push_back(exp_sample(1, rd_list[k]));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (bus.rd_sample !== e) $display("FAIL ovr_sample[%0d]: got %0d want %0d", rd_list[k], bus.rd_sample, e); else passed++;
        end
        n = 0;
        while (bus.dbg_state !== ST_DONE && n < 2000) begin @(negedge clk); n++; end
        checks++; if (bus.dbg_state !== ST_DONE) $display("FAIL ovr_refill_done: got %0d want %0d", bus.dbg_state, ST_DONE); else passed++;
    endtask

    task automatic test_frame_line();
        int n;
        logic [7:0] e;
        ram[VADDR] = 32'h1234_5678;
        pulse(1'b1, 1'b1);
        checks++; if (bus.dbg_state !== ST_VALUE) $display("FAIL fl_value_first: got %0d want %0d", bus.dbg_state, ST_VALUE); else passed++;
        n = 0;
        while (bus.dbg_state !== ST_DONE && n < 2000) begin @(negedge clk); n++; end
        checks++; if (n != 323) $display("FAIL fl_cycles: got %0d want 323", n); else passed++;
        checks++; if (bus.value !== 32'h1234_5678) $display("FAIL fl_value: got %0h want 12345678", bus.value); else passed++;
`ifdef PREFETCH_STATS_EN
        checks++; if (bus.stall_cnt !== 16'd0 || bus.ovr_cnt !== 8'd0) $display("FAIL fl_stats_clear: got %0d/%0d want 0/0", bus.stall_cnt, bus.ovr_cnt); else passed++;
`endif
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            bus.rd_idx = 9'(rd_list[k]);
            exp_q.push_back(exp_sample(2, rd_list[k]));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (bus.rd_sample !== e) $display("FAIL fl_sample[%0d]: got %0d want %0d", rd_list[k], bus.rd_sample, e); else passed++;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] e;
        pulse(1'b0, 1'b1);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (bus.dbg_state !== ST_IDLE) $display("FAIL mid_reset_state: got %0d want %0d", bus.dbg_state, ST_IDLE); else passed++;
        checks++; if (bus.value_valid !== 1'b0 || bus.overrun !== 1'b0) $display("FAIL mid_reset_flags: got %0b/%0b want 0/0", bus.value_valid, bus.overrun); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (bus.dbg_state !== ST_IDLE || bus.mem_addr !== 12'h000) $display("FAIL mid_reset_quiet: got st=%0d addr=%0h want 0/0", bus.dbg_state, bus.mem_addr); else passed++;
        bus.rd_idx = 9'd17;
        exp_q.push_back(8'd0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (bus.rd_sample !== e) $display("FAIL mid_reset_sample: got %0d want %0d", bus.rd_sample, e); else passed++;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) ram[a] = $urandom();
        ram[VADDR] = 32'd999;
        load_pattern(1);
        test_reset();
        test_value();
        test_line();
        test_cpu_interleave();
        test_overrun();
        test_frame_line();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
